// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: per-key 2-FF synchroniser and counter debounce, followed by a
// single-cycle press strobe with lockout while any other key is held.
module keypad_debounce_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key01,
    input  logic        key02,
    input  logic        key03,
    input  logic        key04,
    input  logic        key05,
    input  logic        key06,
    input  logic        key07,
    input  logic        key08,
    input  logic        key09,
    input  logic        key10,
    input  logic        key11,
    input  logic        key12,
    output logic        key_valid,
    output logic [3:0]  key_value,
    output logic        key_pressed,
    output logic [11:0] key_mask
);

    localparam int unsigned      NUM_KEYS = 12;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [11:0]      raw;
    logic [11:0]      key_in;
    logic [11:0]      sync1_q;
    logic [11:0]      sync2_q;
    logic [11:0]      deb_q;
    logic [11:0]      deb_d;
    logic [11:0]      deb_prev_q;
    logic [11:0]      rise;
    logic [CNT_W-1:0] cnt_q [NUM_KEYS];
    logic [CNT_W-1:0] cnt_d [NUM_KEYS];
    logic             accept;
    logic [3:0]       code;

    assign raw = {key12, key11, key10, key09, key08, key07,
                  key06, key05, key04, key03, key02, key01};
    assign key_in = ACTIVE_LOW ? ~raw : raw;

    function automatic logic [3:0] encode(input int idx);
        case (idx)
            9:       encode = 4'd10;
            10:      encode = 4'd0;
            11:      encode = 4'd11;
            default: encode = 4'(idx + 1);
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end
        end
    end

    // A rising key has deb_prev=0 itself, so "all others were 0" reduces to deb_prev==0.
    always_comb begin
        rise   = deb_q & ~deb_prev_q;
        accept = (rise != '0) && (deb_prev_q == '0);
        code   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                code = encode(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            key_valid   <= 1'b0;
            key_value   <= '0;
            key_pressed <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            key_valid   <= accept;
            key_pressed <= |deb_d;
            if (accept) begin
                key_value <= code;
            end
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_mask = deb_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder: directed scenarios plus randomized key activity
// compared against a sliding-window reference model.
module tb_keypad_debounce_encoder;

    localparam int D = 4;
    localparam logic [3:0] KEY_CODE [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                             4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] keys = '0;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        key_pressed;
    logic [11:0] key_mask;

    int checks = 0;
    int errors = 0;

    keypad_debounce_encoder #(
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key01      (keys[0]),
        .key02      (keys[1]),
        .key03      (keys[2]),
        .key04      (keys[3]),
        .key05      (keys[4]),
        .key06      (keys[5]),
        .key07      (keys[6]),
        .key08      (keys[7]),
        .key09      (keys[8]),
        .key10      (keys[9]),
        .key11      (keys[10]),
        .key12      (keys[11]),
        .key_valid  (key_valid),
        .key_value  (key_value),
        .key_pressed(key_pressed),
        .key_mask   (key_mask)
    );

    always #5 clk = ~clk;

    // Reference model: a key's level is accepted once the last D synchronised samples
    // all agree; a strobe follows a rise by one cycle if nothing was held before it.
    logic [11:0]  m_s1, m_s2, m_deb, m_deb_old, m_deb_d, m_rise;
    logic [D-1:0] m_win [12];
    logic [D-1:0] m_win_d [12];
    logic         m_valid, m_valid_d;
    logic [3:0]   m_value, m_value_d;

    always_comb begin
        m_rise    = m_deb & ~m_deb_old;
        m_valid_d = (m_rise != '0) && (m_deb_old == '0);
        m_value_d = m_value;
        for (int i = 11; i >= 0; i--) begin
            if (m_valid_d && m_rise[i]) m_value_d = KEY_CODE[i];
        end
        for (int i = 0; i < 12; i++) begin
            m_win_d[i] = {m_win[i][D-2:0], m_s2[i]};
            m_deb_d[i] = m_deb[i];
            if (&m_win_d[i]) m_deb_d[i] = 1'b1;
            else if (m_win_d[i] == '0) m_deb_d[i] = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1      <= '0;
            m_s2      <= '0;
            m_deb     <= '0;
            m_deb_old <= '0;
            m_valid   <= 1'b0;
            m_value   <= '0;
            for (int i = 0; i < 12; i++) m_win[i] <= '0;
        end else begin
            m_s1      <= keys;
            m_s2      <= m_s1;
            m_deb     <= m_deb_d;
            m_deb_old <= m_deb;
            m_valid   <= m_valid_d;
            m_value   <= m_value_d;
            for (int i = 0; i < 12; i++) m_win[i] <= m_win_d[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic count_strobes(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (key_valid) cnt++;
        end
    endtask

    task automatic wait_strobe(input int budget, output int found, output logic [3:0] val);
        found = 0;
        val   = '0;
        for (int k = 0; k < budget && found == 0; k++) begin
            tick();
            if (key_valid) begin
                found = 1;
                val   = key_value;
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        keys = '0;
        idle(2);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", key_valid);
        end
        checks++;
        if (key_value !== 4'd0) begin
            errors++; $display("FAIL reset_value got %0d want 0", key_value);
        end
        checks++;
        if (key_pressed !== 1'b0) begin
            errors++; $display("FAIL reset_pressed got %b want 0", key_pressed);
        end
        checks++;
        if (key_mask !== 12'h000) begin
            errors++; $display("FAIL reset_mask got %h want 000", key_mask);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_clean_press();
        int n;
        keys[4] = 1'b1;
        tick();  // edge 0
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 4) begin
                checks++;
                if (key_mask !== 12'h000) begin
                    errors++; $display("FAIL press_mask_early got %h want 000", key_mask);
                end
            end
            if (k == 5) begin
                checks++;
                if (key_mask !== 12'h010 || key_pressed !== 1'b1 || key_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL press_mask_edge5 got mask %h pressed %b valid %b want 010 1 0",
                             key_mask, key_pressed, key_valid);
                end
            end
            if (k == 6) begin
                checks++;
                if (key_valid !== 1'b1 || key_value !== 4'd5) begin
                    errors++;
                    $display("FAIL press_strobe_edge6 got valid %b value %0d want 1 5",
                             key_valid, key_value);
                end
            end
            if (k == 7) begin
                checks++;
                if (key_valid !== 1'b0) begin
                    errors++; $display("FAIL press_strobe_width got %b want 0", key_valid);
                end
            end
        end
        count_strobes(12, n);
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL press_no_repeat got %0d strobes want 0", n);
        end
        keys[4] = 1'b0;
        idle(8);
        checks++;
        if (key_mask !== 12'h000 || key_pressed !== 1'b0) begin
            errors++;
            $display("FAIL press_release got mask %h pressed %b want 000 0", key_mask, key_pressed);
        end
    endtask

    task automatic test_bounce_glitch();
        int n, at, bad;
        logic [3:0] val;
        for (int k = 0; k < 4; k++) begin
            keys[2] = (k % 2 == 0);
            tick();
        end
        keys[2] = 1'b1;
        n = 0; at = -1; val = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (key_valid) begin
                n++; at = k; val = key_value;
            end
        end
        checks++;
        if (n != 1 || at != 6 || val !== 4'd3) begin
            errors++;
            $display("FAIL bounce_strobe got count %0d edge %0d value %0d want 1 6 3", n, at, val);
        end
        keys[2] = 1'b0;
        idle(8);
        n = 0; bad = 0;
        for (int k = 0; k < 15; k++) begin
            keys[6] = (k < 3);
            tick();
            if (key_valid) n++;
            if (key_mask !== 12'h000) bad++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL glitch_strobe got %0d strobes want 0", n);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL glitch_mask got %0d nonzero cycles want 0", bad);
        end
    endtask

    task automatic test_encoding_hold();
        int idx [3] = '{10, 11, 9};
        logic [3:0] want [3] = '{4'd0, 4'd11, 4'd10};
        int found, n;
        logic [3:0] val;
        for (int t = 0; t < 3; t++) begin
            keys[idx[t]] = 1'b1;
            wait_strobe(12, found, val);
            checks++;
            if (found != 1 || val !== want[t]) begin
                errors++;
                $display("FAIL encode_%0d got found %0d value %0d want 1 %0d",
                         idx[t] + 1, found, val, want[t]);
            end
            keys[idx[t]] = 1'b0;
            count_strobes(10, n);
            checks++;
            if (n != 0 || key_value !== want[t]) begin
                errors++;
                $display("FAIL hold_%0d got strobes %0d value %0d want 0 %0d",
                         idx[t] + 1, n, key_value, want[t]);
            end
        end
    endtask

    task automatic test_lockout();
        int found, n;
        logic [3:0] val;
        keys[1] = 1'b1;
        wait_strobe(12, found, val);
        checks++;
        if (found != 1 || val !== 4'd2) begin
            errors++; $display("FAIL lockout_first got found %0d value %0d want 1 2", found, val);
        end
        keys[7] = 1'b1;
        count_strobes(12, n);
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL lockout_blocked got %0d strobes want 0", n);
        end
        checks++;
        if (key_mask !== 12'h082) begin
            errors++; $display("FAIL lockout_mask got %h want 082", key_mask);
        end
        keys = '0;
        count_strobes(10, n);
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL lockout_replay got %0d strobes want 0", n);
        end
        keys[7] = 1'b1;
        wait_strobe(12, found, val);
        checks++;
        if (found != 1 || val !== 4'd8) begin
            errors++; $display("FAIL lockout_alone got found %0d value %0d want 1 8", found, val);
        end
        keys = '0;
        idle(10);
    endtask

    task automatic test_simultaneous();
        int found, n;
        logic [3:0] val;
        keys[3] = 1'b1;
        keys[8] = 1'b1;
        count_strobes(14, n);
        checks++;
        if (n != 1 || key_value !== 4'd4) begin
            errors++;
            $display("FAIL simul_first got strobes %0d value %0d want 1 4", n, key_value);
        end
        keys[3] = 1'b0;
        count_strobes(10, n);
        checks++;
        if (n != 0 || key_mask !== 12'h100) begin
            errors++;
            $display("FAIL simul_held got strobes %0d mask %h want 0 100", n, key_mask);
        end
        keys[8] = 1'b0;
        idle(10);
        keys[8] = 1'b1;
        wait_strobe(12, found, val);
        checks++;
        if (found != 1 || val !== 4'd9) begin
            errors++; $display("FAIL simul_repress got found %0d value %0d want 1 9", found, val);
        end
        keys = '0;
        idle(10);
    endtask

    task automatic test_reset_mid();
        int n, at;
        logic [3:0] val;
        keys[5] = 1'b1;
        idle(4);  // edges 0..3: counter now at 2
        rst = 1'b1;
        #1;
        checks++;
        if (key_valid !== 1'b0 || key_value !== 4'd0 || key_pressed !== 1'b0 ||
            key_mask !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid got valid %b value %0d pressed %b mask %h want 0 0 0 000",
                     key_valid, key_value, key_pressed, key_mask);
        end
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        n = 0; at = -1; val = '0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (key_valid) begin
                n++; at = k; val = key_value;
            end
        end
        checks++;
        if (n != 1 || at != 6 || val !== 4'd6) begin
            errors++;
            $display("FAIL reset_refresh got count %0d edge %0d value %0d want 1 6 6", n, at, val);
        end
        checks++;
        if (key_mask !== 12'h020) begin
            errors++; $display("FAIL reset_held_mask got %h want 020", key_mask);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (key_mask !== 12'h000 || key_pressed !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_mask got mask %h pressed %b want 000 0",
                     key_mask, key_pressed);
        end
        @(negedge clk);
        keys = '0;
        rst  = 1'b0;
        idle(10);
    endtask

    task automatic test_random();
        int r, hold, idx;
        for (int seg = 0; seg < 80; seg++) begin
            r   = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 11));
            if (r < 4) keys = '0;
            else if (r < 8) keys = 12'(1 << idx);
            else if (r == 8) keys = 12'(1 << idx) | 12'(1 << $urandom_range(0, 11));
            else keys[idx] = ~keys[idx];
            hold = int'($urandom_range(1, 8));
            for (int k = 0; k < hold; k++) begin
                tick();
                checks++;
                if (key_valid !== m_valid) begin
                    errors++; $display("FAIL rand_valid got %b want %b", key_valid, m_valid);
                end
                checks++;
                if (key_value !== m_value) begin
                    errors++; $display("FAIL rand_value got %0d want %0d", key_value, m_value);
                end
                checks++;
                if (key_mask !== m_deb) begin
                    errors++; $display("FAIL rand_mask got %h want %h", key_mask, m_deb);
                end
                checks++;
                if (key_pressed !== (|m_deb)) begin
                    errors++; $display("FAIL rand_pressed got %b want %b", key_pressed, |m_deb);
                end
            end
        end
        keys = '0;
        idle(10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_glitch();
        test_encoding_hold();
        test_lockout();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
